// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch types and FSM states.
package exe_pkg;
  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;
endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W steps per operation.
module seq_mul #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product,
  output logic              done
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0]  cnt;

  // product is the accumulator value after this cycle's step; on the last step it is the answer.
  always_comb begin
    product = acc;
    if (mplier[cnt]) product = acc + (mcand << cnt);
  end

  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (run) begin
      acc <= product;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, branch resolution, sequential multiply and the EXE/MEM register.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     Val1,
  input  logic [DATA_W-1:0]     Val2,
  input  logic [DATA_W-1:0]     Reg2,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  input  logic [1:0]            Br_type,
  input  logic [3:0]            EXE_CMD,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic                  WB_EN_in,
  output logic                  Br_taken,
  output logic [DATA_W-1:0]     Br_addr,
  output logic                  busy,
  output logic [DATA_W-1:0]     ALU_result,
  output logic [DATA_W-1:0]     Reg2_out,
  output logic [REG_ADDR_W-1:0] Dest_out,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic                  WB_EN,
  output state_t                dbg_state
);
  localparam int SH_W = $clog2(DATA_W);

  state_t                state;
  logic [DATA_W-1:0]     alu_res, mul_product, cap_reg2;
  logic [REG_ADDR_W-1:0] cap_dest;
  logic                  cap_mem_r, cap_mem_w, cap_wb;
  logic                  mul_start, mul_done;
  logic [SH_W-1:0]       shamt;

  assign shamt     = Val2[SH_W-1:0];
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign mul_start = (state == IDLE) && (EXE_CMD == CMD_MUL);

  always_comb begin
    alu_res = '0;
    case (EXE_CMD)
      CMD_ADD: alu_res = Val1 + Val2;
      CMD_SUB: alu_res = Val1 - Val2;
      CMD_AND: alu_res = Val1 & Val2;
      CMD_OR:  alu_res = Val1 | Val2;
      CMD_NOR: alu_res = ~(Val1 | Val2);
      CMD_XOR: alu_res = Val1 ^ Val2;
      CMD_SLL: alu_res = Val1 << shamt;
      CMD_SRA: alu_res = $signed(Val1) >>> shamt;
      CMD_SRL: alu_res = Val1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Branches only resolve in IDLE; while a multiply runs the inputs are stale.
  always_comb begin
    Br_taken = 1'b0;
    if (state == IDLE) begin
      case (Br_type)
        BR_BEZ:  Br_taken = (Val1 == '0);
        BR_BNE:  Br_taken = (Val1 != Reg2);
        BR_JMP:  Br_taken = 1'b1;
        default: Br_taken = 1'b0;
      endcase
    end
  end

  assign Br_addr = PC_in + {Val2[DATA_W-3:0], 2'b00};

  seq_mul #(.DATA_W(DATA_W)) u_seq_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .run     (state == MUL),
    .a       (Val1),
    .b       (Val2),
    .product (mul_product),
    .done    (mul_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ALU_result <= '0;
      Reg2_out   <= '0;
      Dest_out   <= '0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      WB_EN      <= 1'b0;
      cap_reg2   <= '0;
      cap_dest   <= '0;
      cap_mem_r  <= 1'b0;
      cap_mem_w  <= 1'b0;
      cap_wb     <= 1'b0;
    end else begin
      // Bubble by default; overridden when a real result is ready.
      ALU_result <= '0;
      Reg2_out   <= '0;
      Dest_out   <= '0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      WB_EN      <= 1'b0;
      case (state)
        IDLE: begin
          if (EXE_CMD == CMD_MUL) begin
            cap_reg2  <= Reg2;
            cap_dest  <= Dest_in;
            cap_mem_r <= MEM_R_EN_in;
            cap_mem_w <= MEM_W_EN_in;
            cap_wb    <= WB_EN_in;
            state     <= MUL;
          end else begin
            ALU_result <= alu_res;
            Reg2_out   <= Reg2;
            Dest_out   <= Dest_in;
            MEM_R_EN   <= MEM_R_EN_in;
            MEM_W_EN   <= MEM_W_EN_in;
            WB_EN      <= WB_EN_in;
          end
        end
        MUL: begin
          if (mul_done) begin
            ALU_result <= mul_product;
            Reg2_out   <= cap_reg2;
            Dest_out   <= cap_dest;
            MEM_R_EN   <= cap_mem_r;
            MEM_W_EN   <= cap_mem_w;
            WB_EN      <= cap_wb;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, branches, multiply stall, and reset abort.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk, rst;
  logic [31:0] Val1, Val2, Reg2, PC_in;
  logic [4:0]  Dest_in;
  logic [1:0]  Br_type;
  logic [3:0]  EXE_CMD;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic        Br_taken, busy, MEM_R_EN, MEM_W_EN, WB_EN;
  logic [31:0] Br_addr, ALU_result, Reg2_out;
  logic [4:0]  Dest_out;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  exe_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .Val1(Val1), .Val2(Val2), .Reg2(Reg2), .PC_in(PC_in),
    .Dest_in(Dest_in), .Br_type(Br_type), .EXE_CMD(EXE_CMD),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .Br_taken(Br_taken), .Br_addr(Br_addr), .busy(busy), .ALU_result(ALU_result),
    .Reg2_out(Reg2_out), .Dest_out(Dest_out), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .WB_EN(WB_EN), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2,
                            input logic [31:0] pc, input logic [4:0] dest, input logic [1:0] br,
                            input logic [3:0] cmd, input logic mr, input logic mw, input logic wb);
    Val1 = v1; Val2 = v2; Reg2 = r2; PC_in = pc; Dest_in = dest; Br_type = br;
    EXE_CMD = cmd; MEM_R_EN_in = mr; MEM_W_EN_in = mw; WB_EN_in = wb;
  endtask

  task automatic set_nop();
    set_inputs(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, BR_NONE, CMD_ADD, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_inputs(32'h11, 32'h22, 32'h33, 32'h40, 5'd4, BR_NONE, CMD_ADD, 1'b1, 1'b1, 1'b1);
    step(); step();
    n_tests++;
    if (ALU_result !== 32'h0 || Reg2_out !== 32'h0 || Dest_out !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h reg2=%h dest=%0d, required all 0", ALU_result, Reg2_out, Dest_out);
    end
    n_tests++;
    if (MEM_R_EN !== 1'b0 || MEM_W_EN !== 1'b0 || WB_EN !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: mr=%b mw=%b wb=%b busy=%b, required 0", MEM_R_EN, MEM_W_EN, WB_EN, busy);
    end
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required IDLE", dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    set_nop();
    step();
  endtask

  task automatic test_alu();
    logic [3:0]  cmd [9];
    logic [31:0] a   [9];
    logic [31:0] b   [9];
    logic [31:0] exp [9];
    cmd[0] = CMD_ADD; a[0] = 32'h7FFFFFFF; b[0] = 32'h1;        exp[0] = 32'h80000000;
    cmd[1] = CMD_SUB; a[1] = 32'h0;        b[1] = 32'h1;        exp[1] = 32'hFFFFFFFF;
    cmd[2] = CMD_SRA; a[2] = 32'h80000000; b[2] = 32'h4;        exp[2] = 32'hF8000000;
    cmd[3] = CMD_AND; a[3] = 32'hF0F000FF; b[3] = 32'h0FF00F0F; exp[3] = 32'h00F0000F;
    cmd[4] = CMD_OR;  a[4] = 32'hF0F000FF; b[4] = 32'h0FF00F0F; exp[4] = 32'hFFF00FFF;
    cmd[5] = CMD_NOR; a[5] = 32'hF0F000FF; b[5] = 32'h0FF00F0F; exp[5] = 32'h000FF000;
    cmd[6] = CMD_XOR; a[6] = 32'hF0F000FF; b[6] = 32'h0FF00F0F; exp[6] = 32'hFF000FF0;
    cmd[7] = CMD_SLL; a[7] = 32'h1;        b[7] = 32'h25;       exp[7] = 32'h20;
    cmd[8] = CMD_SRL; a[8] = 32'h80000000; b[8] = 32'h1F;       exp[8] = 32'h1;
    for (int i = 0; i < 9; i++) begin
      set_inputs(a[i], b[i], 32'h1000 + i, 32'h0, 5'(i + 5), BR_NONE, cmd[i], 1'b0, 1'b0, 1'b1);
      step();
      n_tests++;
      if (ALU_result !== exp[i] || WB_EN !== 1'b1 || Dest_out !== 5'(i + 5) || Reg2_out !== 32'h1000 + i) begin
        n_fail++;
        $display("FAIL alu_%0d: result=%h wb=%b dest=%0d reg2=%h, required %h 1 %0d %h",
                 i, ALU_result, WB_EN, Dest_out, Reg2_out, exp[i], i + 5, 32'h1000 + i);
      end
    end
    set_nop();
    step();
  endtask

  task automatic test_unlisted();
    set_inputs(32'h5, 32'h6, 32'h77, 32'h0, 5'd3, BR_NONE, 4'b0001, 1'b1, 1'b0, 1'b1);
    step();
    n_tests++;
    if (ALU_result !== 32'h0 || MEM_R_EN !== 1'b1 || WB_EN !== 1'b1 || Dest_out !== 5'd3 || Reg2_out !== 32'h77) begin
      n_fail++;
      $display("FAIL unlisted_cmd: result=%h mr=%b wb=%b dest=%0d reg2=%h, required 0 1 1 3 77",
               ALU_result, MEM_R_EN, WB_EN, Dest_out, Reg2_out);
    end
    set_nop();
    step();
  endtask

  task automatic test_branch();
    set_inputs(32'h3, 32'h2, 32'h4, 32'h100, 5'd0, BR_BNE, CMD_ADD, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (Br_taken !== 1'b1 || Br_addr !== 32'h108) begin
      n_fail++;
      $display("FAIL bne_taken: taken=%b addr=%h, required 1 108", Br_taken, Br_addr);
    end
    Val1 = 32'h4;
    #1;
    n_tests++;
    if (Br_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_not_taken: taken=%b required 0", Br_taken);
    end
    set_inputs(32'h0, 32'hFFFFFFFF, 32'h9, 32'h100, 5'd0, BR_BEZ, CMD_ADD, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (Br_taken !== 1'b1 || Br_addr !== 32'hFC) begin
      n_fail++;
      $display("FAIL bez_taken_back: taken=%b addr=%h, required 1 fc", Br_taken, Br_addr);
    end
    Val1 = 32'h1;
    #1;
    n_tests++;
    if (Br_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL bez_not_taken: taken=%b required 0", Br_taken);
    end
    Br_type = BR_JMP;
    #1;
    n_tests++;
    if (Br_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL jmp_taken: taken=%b required 1", Br_taken);
    end
    Br_type = BR_NONE;
    #1;
    n_tests++;
    if (Br_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL none_not_taken: taken=%b required 0", Br_taken);
    end
    set_nop();
    step();
  endtask

  task automatic test_mul_basic();
    int busy_cnt, bubble_bad, br_bad;
    set_inputs(32'd7, 32'd6, 32'hAA, 32'h0, 5'd12, BR_NONE, CMD_MUL, 1'b0, 1'b0, 1'b1);
    step();
    n_tests++;
    if (busy !== 1'b1 || dbg_state !== MUL || WB_EN !== 1'b0 || ALU_result !== 32'h0) begin
      n_fail++;
      $display("FAIL mul_start: busy=%b state=%0d wb=%b result=%h, required 1 MUL 0 0",
               busy, dbg_state, WB_EN, ALU_result);
    end
    // Inputs that must be ignored while the multiply runs.
    set_inputs(32'd100, 32'd200, 32'h55, 32'h200, 5'd20, BR_JMP, CMD_ADD, 1'b0, 1'b1, 1'b1);
    busy_cnt = 0; bubble_bad = 0; br_bad = 0;
    while (busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      if (WB_EN !== 1'b0 || MEM_W_EN !== 1'b0 || ALU_result !== 32'h0) bubble_bad++;
      if (Br_taken !== 1'b0) br_bad++;
      step();
    end
    n_tests++;
    if (busy_cnt !== 32) begin
      n_fail++;
      $display("FAIL mul_busy_len: busy cycles=%0d required 32", busy_cnt);
    end
    n_tests++;
    if (bubble_bad !== 0 || br_bad !== 0) begin
      n_fail++;
      $display("FAIL mul_bubbles: bad bubbles=%0d bad br_taken=%0d, required 0 0", bubble_bad, br_bad);
    end
    n_tests++;
    if (ALU_result !== 32'd42 || WB_EN !== 1'b1 || Dest_out !== 5'd12 || Reg2_out !== 32'hAA || MEM_W_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_7x6: result=%h wb=%b dest=%0d reg2=%h mw=%b, required 2a 1 12 aa 0",
               ALU_result, WB_EN, Dest_out, Reg2_out, MEM_W_EN);
    end
    set_nop();
    step();
    n_tests++;
    if (WB_EN !== 1'b0 || ALU_result !== 32'h0) begin
      n_fail++;
      $display("FAIL mul_one_cycle: wb=%b result=%h, required 0 0", WB_EN, ALU_result);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt, early;
    set_inputs(32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 5'd7, BR_NONE, CMD_MUL, 1'b0, 1'b0, 1'b1);
    step();
    set_inputs(32'd10, 32'd20, 32'h0, 32'h0, 5'd9, BR_NONE, CMD_ADD, 1'b0, 1'b0, 1'b1);
    busy_cnt = 0; early = 0;
    while (busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      if (ALU_result === 32'd30 || WB_EN !== 1'b0) early++;
      step();
    end
    n_tests++;
    if (busy_cnt !== 32 || early !== 0) begin
      n_fail++;
      $display("FAIL b2b_stall: busy cycles=%0d early outputs=%0d, required 32 0", busy_cnt, early);
    end
    n_tests++;
    if (ALU_result !== 32'hFFFFFFF1 || Dest_out !== 5'd7 || WB_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_neg: result=%h dest=%0d wb=%b, required fffffff1 7 1", ALU_result, Dest_out, WB_EN);
    end
    step();
    n_tests++;
    if (ALU_result !== 32'd30 || Dest_out !== 5'd9 || WB_EN !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_add: result=%h dest=%0d wb=%b busy=%b, required 1e 9 1 0",
               ALU_result, Dest_out, WB_EN, busy);
    end
    set_nop();
    step();
    n_tests++;
    if (ALU_result !== 32'h0 || WB_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_once: result=%h wb=%b, required 0 0", ALU_result, WB_EN);
    end
  endtask

  task automatic test_reset_during_mul();
    set_inputs(32'd3, 32'd3, 32'h0, 32'h0, 5'd6, BR_NONE, CMD_MUL, 1'b0, 1'b0, 1'b1);
    step();
    set_nop();
    for (int i = 0; i < 10; i++) step();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mul_pre: busy=%b required 1", busy);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || dbg_state !== IDLE || ALU_result !== 32'h0 || WB_EN !== 1'b0 || Dest_out !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_mul_abort: busy=%b state=%0d result=%h wb=%b dest=%0d, required 0 IDLE 0 0 0",
               busy, dbg_state, ALU_result, WB_EN, Dest_out);
    end
    set_inputs(32'd2, 32'd2, 32'h0, 32'h0, 5'd2, BR_NONE, CMD_ADD, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step();
    n_tests++;
    if (ALU_result !== 32'd4 || WB_EN !== 1'b1 || Dest_out !== 5'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_then_add: result=%h wb=%b dest=%0d busy=%b, required 4 1 2 0",
               ALU_result, WB_EN, Dest_out, busy);
    end
    set_nop();
    for (int i = 0; i < 25; i++) step();
    n_tests++;
    if (ALU_result !== 32'h0 || WB_EN !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_stale_mul: result=%h wb=%b busy=%b, required 0 0 0", ALU_result, WB_EN, busy);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_unlisted();
    test_branch();
    test_mul_basic();
    test_back_to_back();
    test_reset_during_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
